// File: rtl/ins_cache_assoc_pkg.sv
// Shared types and width helpers for the set-associative instruction cache.
package ins_cache_pkg;

  typedef enum logic {
    IDLE     = 1'b0,
    MEM_READ = 1'b1
  } state_t;

  function automatic int log2_f(input int n);
    return $clog2(n);
  endfunction

  function automatic int tag_w_f(input int addr_w, input int words, input int sets);
    return addr_w - 2 - log2_f(words) - log2_f(sets);
  endfunction

  function automatic int blk_w_f(input int addr_w, input int words);
    return addr_w - 2 - log2_f(words);
  endfunction

  // True when a w-bit counter (zero-extended into v) already holds all-ones.
  function automatic logic cnt_at_max(input logic [63:0] v, input int w);
    return v == (64'hFFFF_FFFF_FFFF_FFFF >> (64 - w));
  endfunction

endpackage

// File: rtl/ins_cache_assoc_if.sv
// Fetch-side and main-memory-side signals of the instruction cache.
interface ins_cache_assoc_if
  import ins_cache_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int WORDS  = 4
);
  localparam int BLK_W = blk_w_f(ADDR_W, WORDS);

  logic                  read;
  logic [ADDR_W-1:0]     address;
  logic                  flush;
  logic [31:0]           readdata;
  logic                  busywait;
  logic                  MAIN_MEM_READ;
  logic [BLK_W-1:0]      MAIN_MEM_ADDRESS;
  logic [32*WORDS-1:0]   MAIN_MEM_READ_DATA;
  logic                  MAIN_MEM_BUSY_WAIT;

  modport master (
    output read, address, flush, MAIN_MEM_READ_DATA, MAIN_MEM_BUSY_WAIT,
    input  readdata, busywait, MAIN_MEM_READ, MAIN_MEM_ADDRESS
  );

  modport slave (
    input  read, address, flush, MAIN_MEM_READ_DATA, MAIN_MEM_BUSY_WAIT,
    output readdata, busywait, MAIN_MEM_READ, MAIN_MEM_ADDRESS
  );
endinterface

// File: rtl/ins_cache_assoc_way.sv
// One cache way: valid/tag/data arrays, combinational lookup and block fill.
module ins_cache_way
  import ins_cache_pkg::*;
#(
  parameter int WORDS = 4,
  parameter int SETS  = 8,
  parameter int OFF_W = 2,
  parameter int IDX_W = 3,
  parameter int TAG_W = 25
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [IDX_W-1:0]    lk_index,
  input  logic [TAG_W-1:0]    lk_tag,
  input  logic [OFF_W-1:0]    lk_offset,
  output logic                lk_hit,
  output logic [31:0]         lk_word,
  input  logic [IDX_W-1:0]    fill_index,
  output logic                fill_valid,
  input  logic                fill_en,
  input  logic [TAG_W-1:0]    fill_tag,
  input  logic [32*WORDS-1:0] fill_data,
  input  logic                inval_all
);

  logic [SETS-1:0]       valid_q;
  logic [TAG_W-1:0]      tag_mem  [SETS];
  logic [32*WORDS-1:0]   data_mem [SETS];
  logic [32*WORDS-1:0]   lk_block;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid_q <= '0;
    end else if (inval_all) begin
      valid_q <= '0;
    end else if (fill_en) begin
      valid_q[fill_index] <= 1'b1;
    end
  end

  // Tag and data need no reset: they are only observed through valid_q.
  always_ff @(posedge clock) begin
    if (fill_en) begin
      tag_mem[fill_index]  <= fill_tag;
      data_mem[fill_index] <= fill_data;
    end
  end

  assign lk_block   = data_mem[lk_index];
  assign lk_hit     = valid_q[lk_index] && (tag_mem[lk_index] == lk_tag);
  assign lk_word    = lk_block[{lk_offset, 5'd0} +: 32];
  assign fill_valid = valid_q[fill_index];

endmodule

// File: rtl/ins_cache_assoc.sv
// Set-associative read-only instruction cache with LRU, flush and hit/miss counters.
//   state    | meaning
//   IDLE     | lookup of all ways; hits served, misses latch block address, flush applied
//   MEM_READ | block request to main memory held until it reports done, then fill
module ins_cache_assoc
  import ins_cache_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int WORDS  = 4,
  parameter int SETS   = 8,
  parameter int WAYS   = 2,
  parameter int CNT_W  = 32
) (
  input  logic              clock,
  input  logic              reset,
  ins_cache_assoc_if.slave  bus,
  output logic [CNT_W-1:0]  hit_count,
  output logic [CNT_W-1:0]  miss_count
);

  localparam int OFF_W = log2_f(WORDS);
  localparam int IDX_W = log2_f(SETS);
  localparam int TAG_W = tag_w_f(ADDR_W, WORDS, SETS);
  localparam int BLK_W = blk_w_f(ADDR_W, WORDS);

  state_t             state_q, state_d;
  logic [BLK_W-1:0]   blk_q;
  logic               pend_q;
  logic [SETS-1:0]    lru_q;
  logic [CNT_W-1:0]   hit_q, miss_q;

  logic [OFF_W-1:0]   req_off;
  logic [IDX_W-1:0]   req_idx;
  logic [TAG_W-1:0]   req_tag;
  logic [IDX_W-1:0]   fill_idx;
  logic [TAG_W-1:0]   fill_tag;
  logic               addr_unused;

  logic [WAYS-1:0]    way_hit;
  logic [WAYS-1:0]    way_fvalid;
  logic [31:0]        way_word [WAYS];
  logic               hit_any;
  logic               hit_way;
  logic [31:0]        hit_word;
  logic               victim;

  logic               busy, mm_read;
  logic [31:0]        rdata;
  logic [BLK_W-1:0]   mm_addr;
  logic               latch_blk, apply_flush, set_pend, do_fill, hit_upd, miss_upd;

  assign req_off     = bus.address[2 +: OFF_W];
  assign req_idx     = bus.address[2+OFF_W +: IDX_W];
  assign req_tag     = bus.address[ADDR_W-1 -: TAG_W];
  assign fill_idx    = blk_q[IDX_W-1:0];
  assign fill_tag    = blk_q[BLK_W-1 -: TAG_W];
  assign addr_unused = ^bus.address[1:0];

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    ins_cache_way #(
      .WORDS (WORDS),
      .SETS  (SETS),
      .OFF_W (OFF_W),
      .IDX_W (IDX_W),
      .TAG_W (TAG_W)
    ) u_way (
      .clock      (clock),
      .reset      (reset),
      .lk_index   (req_idx),
      .lk_tag     (req_tag),
      .lk_offset  (req_off),
      .lk_hit     (way_hit[w]),
      .lk_word    (way_word[w]),
      .fill_index (fill_idx),
      .fill_valid (way_fvalid[w]),
      .fill_en    (do_fill && (victim == 1'(w))),
      .fill_tag   (fill_tag),
      .fill_data  (bus.MAIN_MEM_READ_DATA),
      .inval_all  (apply_flush)
    );
  end

  always_comb begin
    hit_any  = 1'b0;
    hit_way  = 1'b0;
    hit_word = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (way_hit[w]) begin
        hit_any  = 1'b1;
        hit_way  = 1'(w);
        hit_word = way_word[w];
      end
    end
  end

  // Invalid ways are filled lowest index first; LRU only decides among full sets.
  always_comb begin
    victim = lru_q[fill_idx];
    if (WAYS == 1 || !way_fvalid[0]) begin
      victim = 1'b0;
    end else if (!way_fvalid[WAYS-1]) begin
      victim = 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    busy        = 1'b0;
    rdata       = '0;
    mm_read     = 1'b0;
    mm_addr     = '0;
    latch_blk   = 1'b0;
    apply_flush = 1'b0;
    set_pend    = 1'b0;
    do_fill     = 1'b0;
    hit_upd     = 1'b0;
    miss_upd    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.flush || pend_q) begin
          busy        = bus.read;
          apply_flush = 1'b1;
        end else if (bus.read) begin
          if (hit_any) begin
            rdata   = hit_word;
            hit_upd = 1'b1;
          end else begin
            busy      = 1'b1;
            latch_blk = 1'b1;
            miss_upd  = 1'b1;
            state_d   = MEM_READ;
          end
        end
      end
      MEM_READ: begin
        busy     = 1'b1;
        mm_read  = 1'b1;
        mm_addr  = blk_q;
        set_pend = bus.flush;
        if (!bus.MAIN_MEM_BUSY_WAIT) begin
          do_fill = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      blk_q   <= '0;
      pend_q  <= 1'b0;
      lru_q   <= '0;
      hit_q   <= '0;
      miss_q  <= '0;
    end else begin
      state_q <= state_d;
      if (latch_blk) begin
        blk_q <= {req_tag, req_idx};
      end
      if (apply_flush) begin
        pend_q <= 1'b0;
      end else if (set_pend) begin
        pend_q <= 1'b1;
      end
      if (apply_flush) begin
        lru_q <= '0;
      end else if (hit_upd) begin
        lru_q[req_idx] <= (WAYS > 1) ? ~hit_way : 1'b0;
      end else if (do_fill) begin
        lru_q[fill_idx] <= (WAYS > 1) ? ~victim : 1'b0;
      end
      if (hit_upd && !cnt_at_max(64'(hit_q), CNT_W)) begin
        hit_q <= hit_q + CNT_W'(1);
      end
      if (miss_upd && !cnt_at_max(64'(miss_q), CNT_W)) begin
        miss_q <= miss_q + CNT_W'(1);
      end
    end
  end

  assign bus.busywait         = busy;
  assign bus.readdata         = rdata;
  assign bus.MAIN_MEM_READ    = mm_read;
  assign bus.MAIN_MEM_ADDRESS = mm_addr;
  assign hit_count            = hit_q;
  assign miss_count           = miss_q;

endmodule

// File: tb/tb_ins_cache_assoc.sv
// Bench for ins_cache_assoc: a 2-way/32-bit-counter instance and a direct-mapped/4-bit-counter instance.
module tb_ins_cache_assoc;

  logic        clock;
  logic        rst0, rst1;
  logic [31:0] hc0, mc0;
  logic [3:0]  hc1, mc1;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          mem_lat = 3;
  int          mcnt [2];

  int unsigned       mq [16][$];
  longint unsigned   mhit [2];
  longint unsigned   mmiss [2];

  ins_cache_assoc_if #(.ADDR_W(32), .WORDS(4)) bus0 ();
  ins_cache_assoc_if #(.ADDR_W(32), .WORDS(4)) bus1 ();

  ins_cache_assoc #(.ADDR_W(32), .WORDS(4), .SETS(8), .WAYS(2), .CNT_W(32)) dut0 (
    .clock(clock), .reset(rst0), .bus(bus0), .hit_count(hc0), .miss_count(mc0));

  ins_cache_assoc #(.ADDR_W(32), .WORDS(4), .SETS(8), .WAYS(1), .CNT_W(4)) dut1 (
    .clock(clock), .reset(rst1), .bus(bus1), .hit_count(hc1), .miss_count(mc1));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [127:0] blk_data(input logic [27:0] b);
    logic [127:0] r;
    for (int i = 0; i < 4; i++) r[i*32 +: 32] = {4'hC, b[23:0], 2'b00, 2'(i)};
    return r;
  endfunction

  // Main memory: done on the mem_lat-th edge of a request; idle shows a stray "done".
  always @(negedge clock) begin
    if (bus0.MAIN_MEM_READ) begin
      mcnt[0]++;
      bus0.MAIN_MEM_BUSY_WAIT = (mcnt[0] < mem_lat);
      bus0.MAIN_MEM_READ_DATA = blk_data(bus0.MAIN_MEM_ADDRESS);
    end else begin
      mcnt[0] = 0;
      bus0.MAIN_MEM_BUSY_WAIT = 1'b0;
      bus0.MAIN_MEM_READ_DATA = blk_data(28'hFFF_FFFF);
    end
  end

  always @(negedge clock) begin
    if (bus1.MAIN_MEM_READ) begin
      mcnt[1]++;
      bus1.MAIN_MEM_BUSY_WAIT = (mcnt[1] < mem_lat);
      bus1.MAIN_MEM_READ_DATA = blk_data(bus1.MAIN_MEM_ADDRESS);
    end else begin
      mcnt[1] = 0;
      bus1.MAIN_MEM_BUSY_WAIT = 1'b0;
      bus1.MAIN_MEM_READ_DATA = blk_data(28'hFFF_FFFF);
    end
  end

  // Reference model: each set is a recency-ordered list of tags (front = least recent).
  function automatic longint unsigned cap(input int d);
    return (d == 1) ? 64'd15 : 64'hFFFF_FFFF;
  endfunction

  function automatic bit mpeek(input int d, input logic [31:0] a);
    int k;
    k = d*8 + int'(a[6:4]);
    for (int i = 0; i < mq[k].size(); i++) if (mq[k][i] == (a >> 7)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit mlookup(input int d, input logic [31:0] a);
    int k;
    int unsigned t;
    k = d*8 + int'(a[6:4]);
    t = a >> 7;
    for (int i = 0; i < mq[k].size(); i++) begin
      if (mq[k][i] == t) begin
        mq[k].delete(i);
        mq[k].push_back(t);
        if (mhit[d] < cap(d)) mhit[d]++;
        return 1'b1;
      end
    end
    if (mq[k].size() >= ((d == 1) ? 1 : 2)) void'(mq[k].pop_front());
    mq[k].push_back(t);
    if (mmiss[d] < cap(d)) mmiss[d]++;
    return 1'b0;
  endfunction

  function automatic void mflush(input int d);
    for (int s = 0; s < 8; s++) mq[d*8+s].delete();
  endfunction

  function automatic void mreset(input int d);
    mflush(d);
    mhit[d]  = 0;
    mmiss[d] = 0;
  endfunction

  task automatic drive(input int d, input bit rd, input logic [31:0] a, input bit fl);
    if (d == 0) begin
      bus0.read = rd; bus0.address = a; bus0.flush = fl;
    end else begin
      bus1.read = rd; bus1.address = a; bus1.flush = fl;
    end
  endtask

  function automatic logic busy_of(input int d);
    return (d == 1) ? bus1.busywait : bus0.busywait;
  endfunction
  function automatic logic mmread(input int d);
    return (d == 1) ? bus1.MAIN_MEM_READ : bus0.MAIN_MEM_READ;
  endfunction
  function automatic logic [63:0] mmaddr(input int d);
    return (d == 1) ? 64'(bus1.MAIN_MEM_ADDRESS) : 64'(bus0.MAIN_MEM_ADDRESS);
  endfunction
  function automatic logic [63:0] rdata_of(input int d);
    return (d == 1) ? 64'(bus1.readdata) : 64'(bus0.readdata);
  endfunction
  function automatic logic [63:0] hc_of(input int d);
    return (d == 1) ? 64'(hc1) : 64'(hc0);
  endfunction
  function automatic logic [63:0] mc_of(input int d);
    return (d == 1) ? 64'(mc1) : 64'(mc0);
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One fetch, entered just after a rising edge. fl: 0 none, 1 flush with request, 2 flush during refill.
  task automatic fetch(input int d, input logic [31:0] a, input int fl);
    int           exp_stall;
    int           stall;
    bit           fl_set;
    logic [127:0] blk;
    exp_stall = 0;
    if (fl == 1) begin
      mflush(d);
      exp_stall = 1;
    end
    if (!mlookup(d, a)) begin
      exp_stall += mem_lat + 1;
      if (fl == 2) begin
        mflush(d);
        void'(mlookup(d, a));
        exp_stall += mem_lat + 2;
      end
      void'(mlookup(d, a));
    end
    blk = blk_data(a[31:4]);
    drive(d, 1'b1, a, fl == 1);
    stall  = 0;
    fl_set = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clock);
      if (mmread(d)) begin
        check("mem_address", mmaddr(d), 64'(a[31:4]));
        if (fl == 2 && !fl_set) begin
          drive(d, 1'b1, a, 1'b1);
          fl_set = 1'b1;
        end
      end
      if (!busy_of(d)) break;
      stall++;
      @(posedge clock);
      #1;
      drive(d, 1'b1, a, 1'b0);
    end
    check("stall_cycles", 64'(stall), 64'(exp_stall));
    check("readdata", rdata_of(d), 64'(blk[{a[3:2], 5'd0} +: 32]));
    check("mem_read_after_fill", 64'(mmread(d)), 64'd0);
    @(posedge clock);
    #1;
    drive(d, 1'b0, a, 1'b0);
    check("hit_count", hc_of(d), mhit[d]);
    check("miss_count", mc_of(d), mmiss[d]);
  endtask

  initial begin
    int          d;
    int          fl;
    int          r;
    logic [31:0] a;

    rst0 = 1'b0;
    rst1 = 1'b0;
    drive(0, 1'b0, 32'h0, 1'b0);
    drive(1, 1'b0, 32'h0, 1'b0);
    mreset(0);
    mreset(1);
    repeat (3) @(posedge clock);
    #1;
    check("rst_busywait", 64'(bus0.busywait), 64'd0);
    check("rst_readdata", 64'(bus0.readdata), 64'd0);
    check("rst_mem_read", 64'(bus0.MAIN_MEM_READ), 64'd0);
    check("rst_mem_address", 64'(bus0.MAIN_MEM_ADDRESS), 64'd0);
    check("rst_hit_count", 64'(hc0), 64'd0);
    check("rst_miss_count", 64'(mc0), 64'd0);
    check("rst_dm_miss_count", 64'(mc1), 64'd0);
    @(negedge clock);
    rst0 = 1'b1;
    rst1 = 1'b1;
    @(posedge clock);
    #1;

    // Cold fetch, then hits in the same block
    mem_lat = 3;
    fetch(0, 32'h040, 0);
    fetch(0, 32'h044, 0);
    fetch(0, 32'h048, 0);
    fetch(0, 32'h04C, 0);

    // LRU eviction in set 4
    fetch(0, 32'h440, 0);
    fetch(0, 32'h040, 0);
    fetch(0, 32'h840, 0);
    fetch(0, 32'h040, 0);
    fetch(0, 32'h440, 0);

    // Flush during refill, then flush with a request
    fetch(0, 32'h0C0, 2);
    fetch(0, 32'h0C4, 0);
    fetch(0, 32'h0C8, 1);

    // Reset during the second refill cycle
    drive(0, 1'b1, 32'h100, 1'b0);
    @(negedge clock);
    check("mid_rst_req_busy", 64'(bus0.busywait), 64'd1);
    @(negedge clock);
    @(negedge clock);
    check("mid_rst_mem_read_before", 64'(bus0.MAIN_MEM_READ), 64'd1);
    rst0 = 1'b0;
    drive(0, 1'b0, 32'h100, 1'b0);
    #1;
    check("mid_rst_mem_read", 64'(bus0.MAIN_MEM_READ), 64'd0);
    check("mid_rst_busywait", 64'(bus0.busywait), 64'd0);
    check("mid_rst_hit_count", 64'(hc0), 64'd0);
    check("mid_rst_miss_count", 64'(mc0), 64'd0);
    mreset(0);
    repeat (4) @(negedge clock);
    rst0 = 1'b1;
    @(posedge clock);
    #1;
    fetch(0, 32'h100, 0);
    fetch(0, 32'h104, 0);

    // Direct-mapped thrash and 4-bit counter saturation
    for (int i = 0; i < 20; i++) fetch(1, (i % 2 == 1) ? 32'h440 : 32'h040, 0);
    check("dm_miss_saturated", 64'(mc1), 64'd15);

    // Randomized traffic on both instances
    for (int n = 0; n < 80; n++) begin
      d       = ($urandom_range(0, 3) == 0) ? 1 : 0;
      a       = (32'($urandom_range(0, 3)) << 7) | (32'($urandom_range(0, 7)) << 4)
              | (32'($urandom_range(0, 3)) << 2);
      mem_lat = $urandom_range(1, 5);
      r       = $urandom_range(0, 9);
      fl      = 0;
      if (r == 0) fl = 1;
      else if (r == 1 && !mpeek(d, a)) fl = 2;
      fetch(d, a, fl);
    end

    // Idle: no request means no stall, zero data and frozen counters
    drive(0, 1'b0, 32'h040, 1'b0);
    repeat (2) @(posedge clock);
    #1;
    check("idle_busywait", 64'(bus0.busywait), 64'd0);
    check("idle_readdata", 64'(bus0.readdata), 64'd0);
    check("idle_hit_count", 64'(hc0), mhit[0]);
    check("idle_miss_count", 64'(mc0), mmiss[0]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ins_cache_assoc.md
# ins_cache_assoc

Parametrised, set-associative, read-only instruction cache between the IF-stage PC and the block-wide instruction main memory. It is the successor to the current direct-mapped instruction cache and keeps the same CPU-side read/busywait handshake and main-memory port naming. It adds configurable sets, ways and block size, full-width tags, LRU replacement, whole-cache flush, and hit/miss counters.

## Interface
- `ADDR_W`, 32, byte address width.
- `WORDS`, 4, 32-bit words per block; power of two, ≥2.
- `SETS`, 8, number of sets; power of two.
- `WAYS`, 2, associativity; 1 or 2.
- `CNT_W`, 32, performance counter width.

Derived widths:
- `OFF_W = log2(WORDS)`.
- `IDX_W = log2(SETS)`.
- `TAG_W = ADDR_W-2-OFF_W-IDX_W`.

Ports (width, then meaning):
- `clock` in, 1: single clock, all state on rising edge.
- `reset` in, 1: asynchronous, active-low.
- `read` in, 1: fetch request, level.
- `address` in, ADDR_W: PC; bits [1:0] ignored.
- `flush` in, 1: invalidate all lines, level.
- `readdata` out, 32: fetched instruction.
- `busywait` out, 1: stall the fetch stage.
- `MAIN_MEM_READ` out, 1: block read request.
- `MAIN_MEM_ADDRESS` out, ADDR_W-2-OFF_W: block address `{tag,index}`.
- `MAIN_MEM_READ_DATA` in, 32*WORDS: refill block; word 0 is in the LSBs.
- `MAIN_MEM_BUSY_WAIT` in, 1: memory not yet done.
- `hit_count` out, CNT_W: saturating count of hits.
- `miss_count` out, CNT_W: saturating count of misses.

## Operation
Address decode:
- offset = `address[2+OFF_W-1:2]`
- index = next IDX_W bits
- tag = remaining upper bits

Per line: valid bit, tag, data block. Per set: one LRU bit, which points to the way to evict.

FSM states:
- **IDLE**
  - Combinational lookup of all ways.
  - `read` with a hit: `readdata` = selected word, `busywait`=0. LRU updates at the edge to the other way. `hit_count` increments.
  - `read` with a miss: `busywait`=1. The block address is latched. `miss_count` increments. Next state is MEM_READ.
  - `flush` has priority over `read`. At the edge, all valid bits and LRU bits clear. `busywait`=1 in that cycle, and the request is then re-looked-up.
- **MEM_READ**
  - `MAIN_MEM_READ`=1, `MAIN_MEM_ADDRESS` = latched block address, `busywait`=1.
  - On an edge where `MAIN_MEM_BUSY_WAIT`=0: write the block, tag and valid into the victim way. Point LRU away from the victim. Next state is IDLE.
- Victim selection: first invalid way, lowest index first; otherwise the way named by LRU. When WAYS=1, always way 0.
- Refill always targets the latched address, even if `address` changes during MEM_READ. After returning to IDLE, the current `address` is looked up fresh.
- `flush` asserted during MEM_READ is held pending. It is applied in the first IDLE cycle, before any lookup, so the just-filled line is also invalidated.
- When `read`=0: `busywait`=0, no counter or LRU change, `readdata` is don't-care (driven 0).
- Counters saturate at all-ones and do not wrap.

## Timing
- Reset values: `busywait`=0, `readdata`=0, `MAIN_MEM_READ`=0, `MAIN_MEM_ADDRESS`=0, counters 0. All valid and LRU bits are cleared, state is IDLE.
- Reset asserted mid-refill: immediate return to IDLE, `MAIN_MEM_READ` drops asynchronously, and the late memory response is ignored.
- Hit latency: 0 cycles. Data and `busywait`=0 are valid in the same cycle as `read`.
- Miss: `busywait` rises combinationally in the request cycle. For memory latency L (L edges in MEM_READ with the last having `MAIN_MEM_BUSY_WAIT`=0), the stall is L+1 cycles. The hit returns in the IDLE cycle after the fill.
- `MAIN_MEM_READ` is held high, with a stable address, until the fill edge. It deasserts in the next cycle.
- `read` and `address` must be held stable by the CPU while `busywait`=1. The sole exception is an address change during MEM_READ, which is tolerated as described under Operation.

## Structure
Shared package `ins_cache_pkg` holds:
- the state enum (`IDLE`, `MEM_READ`);
- width-derivation functions: log2, TAG_W, block address width;
- the counter saturation helper.

Sub-module `ins_cache_way` holds one way's tag/valid/data arrays. It does the lookup (hit, word select) and the fill write, and is instantiated WAYS times. The top level owns the FSM, LRU, counters and flush logic.

## Test plan
Default parameters (index = `address[6:4]`, offset = `address[3:2]`) and memory latency L=3 unless stated.

1. **Reset then cold fetch.** Reset low, then read 0x0000_0040. Expect `busywait` high for 4 cycles. `MAIN_MEM_ADDRESS`=0x0000004 during MEM_READ, `readdata` = word 0 of the block, `miss_count`=1.
2. **Hit in the same block.** Read 0x44, 0x48, 0x4C back-to-back. Expect 0-cycle stalls, the correct words, and `hit_count`=3.
3. **LRU eviction.** Fill 0x040 and 0x440 (both index 4). Read 0x040 (hit). Read 0x840 (miss, evicts 0x440). Then 0x040 is a hit and 0x440 is a miss.
4. **Flush during refill.** Assert `flush` during the MEM_READ of 0x0C0. Expect the fill to complete and the next read of 0x0C0 to miss again. All counters must be consistent.
5. **Reset mid-refill.** Pull reset low in the second MEM_READ cycle. Expect `MAIN_MEM_READ`=0 immediately, the later memory completion ignored, and the next read of that address to miss.
6. **Direct-mapped and counter saturation.** Set WAYS=1 and CNT_W=4. Fetch 0x040 and 0x440 alternately. Expect every fetch to miss and `miss_count` to saturate at 15.
